// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the scanned 7-segment display path.
//   - Active-low glyph constants (bit 0 = segment a ... bit 6 = segment g)
//   - DASH_CODE: the BCD nibble that renders as a single '-' (segment g)
//   - state_t: scanner FSM states
//   - Width helpers used to size ports and counters from parameters
package seg_pkg;

  // Active-low glyphs: a 0 lights the segment.
  localparam logic [6:0] GLYPH_0      = 7'h40;
  localparam logic [6:0] GLYPH_1      = 7'h79;
  localparam logic [6:0] GLYPH_2      = 7'h24;
  localparam logic [6:0] GLYPH_3      = 7'h30;
  localparam logic [6:0] GLYPH_4      = 7'h19;
  localparam logic [6:0] GLYPH_5      = 7'h12;
  localparam logic [6:0] GLYPH_6      = 7'h02;
  localparam logic [6:0] GLYPH_7      = 7'h78;
  localparam logic [6:0] GLYPH_8      = 7'h00;
  localparam logic [6:0] GLYPH_9      = 7'h10;
  localparam logic [6:0] GLYPH_DASH   = 7'h3F;
  localparam logic [6:0] GLYPH_BLANK  = 7'h7F;
  localparam logic [6:0] GLYPH_ALL_ON = 7'h00;

  localparam logic [3:0] DASH_CODE = 4'hE;

  typedef enum logic {
    SCAN,
    BLANK
  } state_t;

  // Width of a selector over n items; never below one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold 0..n; never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD nibble to active-low 7-segment glyph.
//   bcd  in  4  nibble to render (0-9 digits, DASH_CODE = '-', others blank)
//   seg  out 7  active-low segments, seg[0]=a ... seg[6]=g
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    seg = GLYPH_BLANK;
    case (bcd)
      4'd0:      seg = GLYPH_0;
      4'd1:      seg = GLYPH_1;
      4'd2:      seg = GLYPH_2;
      4'd3:      seg = GLYPH_3;
      4'd4:      seg = GLYPH_4;
      4'd5:      seg = GLYPH_5;
      4'd6:      seg = GLYPH_6;
      4'd7:      seg = GLYPH_7;
      4'd8:      seg = GLYPH_8;
      4'd9:      seg = GLYPH_9;
      DASH_CODE: seg = GLYPH_DASH;
      default:   seg = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed N-digit 7-segment scanner with paged content,
// per-digit blink and dead-time blanking between digits.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   page_bcd     in   PAGES*DIGITS BCD nibbles, page p digit i at [(p*DIGITS+i)*4 +: 4]
//   page_sel     in   requested page, adopted only at frame end
//   blink_mask   in   digits blanked during the blink-off half-period
//   dp_mask      in   decimal point lit per digit
//   lamp_test    in   all segments and dp on for every scanned digit
//   seg          out  active-low segments a..g
//   dp           out  active-low decimal point
//   an           out  active-low anode strobes, at most one low
//   digit_idx    out  digit owning the current slot
//   page_act     out  page currently displayed
//   blink_phase  out  1 = blink-off half-period
//   frame_done   out  one-cycle pulse on the last clock of each frame
// Every output is a flop; slot content is captured on the SCAN entry edge
// and held for the whole slot.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int PAGES        = 2,
  parameter int SCAN_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PAGES*DIGITS*4-1:0]      page_bcd,
  input  logic [sel_width(PAGES)-1:0]    page_sel,
  input  logic [DIGITS-1:0]              blink_mask,
  input  logic [DIGITS-1:0]              dp_mask,
  input  logic                           lamp_test,
  output logic [6:0]                     seg,
  output logic                           dp,
  output logic [DIGITS-1:0]              an,
  output logic [$clog2(DIGITS)-1:0]      digit_idx,
  output logic [sel_width(PAGES)-1:0]    page_act,
  output logic                           blink_phase,
  output logic                           frame_done
);

  localparam int IW = $clog2(DIGITS);
  localparam int SW = cnt_width(SCAN_CYCLES);
  localparam int BW = cnt_width(BLANK_CYCLES);
  localparam int FW = cnt_width(BLINK_FRAMES);

  localparam logic [IW-1:0] LAST_DIGIT = IW'(DIGITS - 1);
  localparam logic          HAS_BLANK  = (BLANK_CYCLES > 0);

  // ---------------------------------------------------------------------------
  // Scanner state
  // ---------------------------------------------------------------------------
  state_t          state, state_nxt;
  logic [SW-1:0]   scan_cnt, scan_cnt_nxt;
  logic [BW-1:0]   blank_cnt, blank_cnt_nxt;
  logic [IW-1:0]   idx_nxt;
  logic [FW-1:0]   frame_cnt;
  logic            enter_scan;
  logic            enter_blank;
  logic            frame_end;

  // Counters load N-1 on state entry and count down; the state ends on the
  // clock where its counter reads zero.
  always_comb begin
    state_nxt     = state;
    scan_cnt_nxt  = scan_cnt;
    blank_cnt_nxt = blank_cnt;
    idx_nxt       = digit_idx;
    enter_scan    = 1'b0;
    enter_blank   = 1'b0;

    case (state)
      SCAN: begin
        if (scan_cnt == '0) begin
          if (HAS_BLANK) begin
            state_nxt     = BLANK;
            blank_cnt_nxt = BW'(BLANK_CYCLES - 1);
            enter_blank   = 1'b1;
          end else begin
            enter_scan = 1'b1;
          end
        end else begin
          scan_cnt_nxt = scan_cnt - 1'b1;
        end
      end
      BLANK: begin
        if (blank_cnt == '0) begin
          enter_scan = 1'b1;
        end else begin
          blank_cnt_nxt = blank_cnt - 1'b1;
        end
      end
      default: state_nxt = BLANK;
    endcase

    if (enter_scan) begin
      state_nxt    = SCAN;
      scan_cnt_nxt = SW'(SCAN_CYCLES - 1);
      idx_nxt      = (digit_idx == LAST_DIGIT) ? '0 : digit_idx + 1'b1;
    end
  end

  // frame_end is true on the edge that enters the final clock of the last
  // digit's slot, so the registered frame_done is high during that clock.
  // The final clock is the last BLANK clock, or the last SCAN clock when
  // there is no dead time.
  always_comb begin
    if (HAS_BLANK) begin
      frame_end = (state_nxt == BLANK) && (blank_cnt_nxt == '0) &&
                  (idx_nxt == LAST_DIGIT);
    end else begin
      frame_end = (state_nxt == SCAN) && (scan_cnt_nxt == '0) &&
                  (idx_nxt == LAST_DIGIT);
    end
  end

  // Reset parks the scanner in an expired BLANK of the last digit, so the
  // first clock after release enters SCAN of digit 0.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BLANK;
      scan_cnt  <= '0;
      blank_cnt <= '0;
      digit_idx <= LAST_DIGIT;
    end else begin
      state     <= state_nxt;
      scan_cnt  <= scan_cnt_nxt;
      blank_cnt <= blank_cnt_nxt;
      digit_idx <= idx_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame bookkeeping: page adoption and blink phase
  // ---------------------------------------------------------------------------
  // page_act and blink_phase change at least one clock before digit 0's
  // SCAN entry, so the whole next frame sees a consistent page and phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done  <= 1'b0;
      page_act    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        // An out-of-range request is ignored and the current page kept.
        if (int'(page_sel) < PAGES) begin
          page_act <= page_sel;
        end
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot content, evaluated for the digit about to be entered
  // ---------------------------------------------------------------------------
  logic [3:0] slot_nibble;
  logic [6:0] slot_glyph;
  logic [6:0] slot_seg;
  logic       slot_dp;
  logic       slot_blink_off;

  assign slot_nibble    = page_bcd[(int'(page_act) * DIGITS + int'(idx_nxt)) * 4 +: 4];
  assign slot_blink_off = blink_phase & blink_mask[idx_nxt];

  seg7_decode u_decode (
    .bcd (slot_nibble),
    .seg (slot_glyph)
  );

  // Lamp test overrides blink, blink overrides normal content. A blinked
  // digit keeps its anode strobed so scan timing and brightness are unchanged.
  always_comb begin
    slot_seg = slot_glyph;
    slot_dp  = ~dp_mask[idx_nxt];
    if (lamp_test) begin
      slot_seg = GLYPH_ALL_ON;
      slot_dp  = 1'b0;
    end else if (slot_blink_off) begin
      slot_seg = GLYPH_BLANK;
      slot_dp  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: an, seg and dp always change on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= GLYPH_BLANK;
      dp  <= 1'b1;
    end else if (enter_scan) begin
      an  <= ~(DIGITS'(1) << idx_nxt);
      seg <= slot_seg;
      dp  <= slot_dp;
    end else if (enter_blank) begin
      an  <= '1;
      seg <= GLYPH_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised, time-multiplexed N-digit 7-segment scanner with paged content, per-digit blink and dead-time blanking. It sits between the clock/calendar counters (after BCD split) and the board's shared-cathode-bus display. It replaces one static segment output per digit with one scanned segment bus plus one-hot anode strobes. Page switching (time/date/alarm…) happens only on frame boundaries, so the display never tears.

## Interface
- DIGITS, 8: number of scanned digits (2..16)
- PAGES, 2: number of selectable content pages (1..4)
- SCAN_CYCLES, 50000: clocks each digit is lit (≥1)
- BLANK_CYCLES, 500: dead-time clocks between digits, all off (≥0)
- BLINK_FRAMES, 64: frames per blink half-period (≥1)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- page_bcd  in  PAGES*DIGITS*4  BCD nibbles; page p, digit i at [(p*DIGITS+i)*4 +: 4]
- page_sel  in  $clog2(PAGES) (min 1)  requested page
- blink_mask  in  DIGITS  digits blanked during the off blink phase
- dp_mask  in  DIGITS  decimal point lit per digit
- lamp_test  in  1  all segments and dp on for every scanned digit
- seg  out  7  segment drive, active-low, seg[0]=a … seg[6]=g
- dp  out  1  decimal point, active-low
- an  out  DIGITS  anode strobes, active-low, at most one low
- digit_idx  out  $clog2(DIGITS)  digit currently in its slot
- page_act  out  width of page_sel  page currently displayed
- blink_phase  out  1  1 = blink-off half-period
- frame_done  out  1  one-cycle pulse at end of each frame

## Operation
- FSM states: SCAN, BLANK. Reset enters BLANK with digit_idx = DIGITS-1 and the blank counter expired, so the first SCAN is digit 0 on the first clock after reset release.
- SCAN: an[digit_idx]=0 for SCAN_CYCLES clocks, then BLANK. If BLANK_CYCLES=0, go directly to SCAN of the next digit.
- BLANK: an all 1, seg all 1, dp 1, for BLANK_CYCLES clocks. Then digit_idx increments, wrapping DIGITS-1 → 0, and the FSM enters SCAN.
- Slot data: the nibble for (page_act, digit_idx), blink_mask, dp_mask and lamp_test are sampled on the SCAN entry edge. They are held for the whole slot; input changes mid-slot have no visible effect.
- Decode:
  - 0–9: standard glyphs
  - 4'hE: '-' (g only)
  - 4'hA–D and 4'hF: blank
- Priority: lamp_test (seg=0, dp=0) > blink (blink_phase & blink_mask[i] → seg=7'h7F, dp=1, anode still strobed) > normal decode.
- Frame end: frame_done pulses on the last clock of digit DIGITS-1's slot (last BLANK clock, or last SCAN clock if BLANK_CYCLES=0). On that edge:
  - page_act ← page_sel. Out-of-range page_sel (≥PAGES) is ignored and page_act is held.
  - A frame counter increments. On reaching BLINK_FRAMES it clears and blink_phase toggles.
- Reset mid-slot forces all outputs to their reset values immediately (asynchronous).

## Timing
- Reset values:
  - seg=7'h7F, dp=1, an all 1, digit_idx=DIGITS-1, page_act=0, blink_phase=0, frame_done=0
  - Internal: FSM=BLANK, frame counter 0
- All outputs are registered. an, seg and dp change on the same edge; there is no combinational path from any input to any output.
- Slot length = SCAN_CYCLES + BLANK_CYCLES clocks. Frame length = DIGITS × slot.
- Page change latency: visible from digit 0 of the frame after the frame_done that sampled page_sel. Worst case is one frame plus one clock.
- Blink half-period = BLINK_FRAMES frames exactly.
- Counter widths are derived from parameters with $clog2(max+1); no wrap-around occurs inside a slot.

## Structure
- Shared package (seg_pkg):
  - segment glyph constants for 0–9, DASH and BLANK (active-low, a..g)
  - the DASH code 4'hE
  - FSM state enum {SCAN, BLANK}
- Sub-module seg7_decode: combinational 4-bit → 7-bit decoder using seg_pkg constants. It is instantiated once, on the sampled nibble.
- Top holds the FSM, slot and blank counters, digit index, frame/blink counter, page register and output registers.

## Test plan
Bench parameters: DIGITS=4, PAGES=2, SCAN_CYCLES=4, BLANK_CYCLES=1, BLINK_FRAMES=2, unless noted.
- Reset, then release:
  - an cycles 1110 → 1111 → 1101 → 1111 → 1011 → 1111 → 0111 → 1111 with 4/1 clock spacing
  - frame_done high on clock 20 only; never more than one an bit low
- Page 0 = 1,2,3,4 (digits 0..3) and page 1 = 9,8,E,F, with page_sel=1 asserted mid-frame:
  - current frame still shows 1,2,3,4
  - next frame shows 9,8,'-' (7'h3F), blank
- blink_mask=4'b0010: digit 1 seg=7'h7F with an[1]=0 during frames 3–4 and 7–8; normal in frames 1–2 and 5–6. blink_phase toggles every 40 clocks.
- lamp_test=1 together with blink_mask=4'hF in the off phase: seg=0 and dp=0 on every digit.
- Variant BLANK_CYCLES=0: an walks 1110 → 1101 → 1011 → 0111 with no all-off clock; frame = 16 clocks.
- rst_n low mid-SCAN of digit 2: outputs return to reset values within the same cycle. After release, scanning restarts at digit 0 and page_act=0.
